// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// Stall statistics are enabled by defining SPRAM_ARB_STATS_EN.
package spram_arb_pkg;

    localparam int STAT_CNT_W = 16;
    localparam int MAX_REQ    = 8;

    typedef logic [2:0] req_idx_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/spram_rr_arbiter.sv
// Round-robin grant logic with its rotating priority pointer.
// Search starts at rr_ptr; pointer moves past the winner on accept.
module spram_rr_arbiter
    import spram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] rr_ptr;

    // Walk from the farthest offset back so the nearest valid wins last.
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (valid[j]) begin
                grant     = '0;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            if (int'(grant_idx) == NUM_REQ - 1) rr_ptr <= '0;
            else                                rr_ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM among NUM_REQ requesters, one access per cycle.
// Optional per-requester stall counters: define SPRAM_ARB_STATS_EN.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid_in,
    input  logic [NUM_REQ-1:0]               req_we_in,
    input  logic [NUM_REQ*RAM_ADDR_BITS-1:0] req_addr_in,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]     req_wdata_in,
    output logic [NUM_REQ-1:0]               req_ready_out,
    output logic [NUM_REQ-1:0]               rsp_valid_out,
    output logic [RAM_WIDTH-1:0]             rsp_rdata_out,
`ifdef SPRAM_ARB_STATS_EN
    output logic [NUM_REQ*STAT_CNT_W-1:0]    stall_cnt_out,
`endif
    output logic                             ram_we_out,
    output logic [RAM_ADDR_BITS-1:0]         ram_addr_out,
    output logic [RAM_WIDTH-1:0]             ram_wdata_out,
    input  logic [RAM_WIDTH-1:0]             ram_rdata_in
);

    localparam int IDX_W = clog2_min1(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               accept;
    logic [NUM_REQ-1:0] rsp_q;

    assign accept = |req_valid_in;

    spram_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid_in),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready_out = grant;

    // Idle cycles park the port on a read of address 0.
    always_comb begin
        ram_we_out    = 1'b0;
        ram_addr_out  = '0;
        ram_wdata_out = '0;
        if (accept) begin
            ram_we_out    = req_we_in[grant_idx];
            ram_addr_out  = req_addr_in[grant_idx*RAM_ADDR_BITS +: RAM_ADDR_BITS];
            ram_wdata_out = req_wdata_in[grant_idx*RAM_WIDTH +: RAM_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else if (accept && !ram_we_out) begin
            rsp_q <= grant;
        end else begin
            rsp_q <= '0;
        end
    end

    assign rsp_valid_out = rsp_q;
    assign rsp_rdata_out = ram_rdata_in;

`ifdef SPRAM_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [STAT_CNT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (req_valid_in[i] && !grant[i] && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
        assign stall_cnt_out[i*STAT_CNT_W +: STAT_CNT_W] = cnt;
    end
`endif

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port RAM (1-cycle registered read; read data held during write cycles) between NUM_REQ requesters in the TPU memory controller.
- Accepts at most one request per cycle, drives the RAM port and routes 1-cycle-latency read data back to the issuing requester.
- Sits between the TPU load/store/weight-fetch engines and the RAM macro.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- RAM_WIDTH, 32, data width in bits.
- RAM_ADDR_BITS, 10, address width in bits.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid_in  input  NUM_REQ  per-requester request valid.
- req_we_in  input  NUM_REQ  per-requester write enable (0 = read).
- req_addr_in  input  NUM_REQ*RAM_ADDR_BITS  packed addresses; requester i at slice i.
- req_wdata_in  input  NUM_REQ*RAM_WIDTH  packed write data.
- req_ready_out  output  NUM_REQ  one-hot grant; accept = valid & ready.
- rsp_valid_out  output  NUM_REQ  read-data valid, one-hot.
- rsp_rdata_out  output  RAM_WIDTH  read data, shared by all requesters; qualified by rsp_valid_out.
- ram_we_out  output  1  to RAM write enable.
- ram_addr_out  output  RAM_ADDR_BITS  to RAM address.
- ram_wdata_out  output  RAM_WIDTH  to RAM write data.
- ram_rdata_in  input  RAM_WIDTH  from RAM read data.

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr = 0; rsp_valid_out = 0.
  - Any read accepted in the cycle reset asserts is dropped; no response is ever issued for it.
- Grant (combinational):
  - Search req_valid_in starting at index rr_ptr, wrapping modulo NUM_REQ; the first valid index wins.
  - req_ready_out has exactly the winner bit set; all zeros if no valid.
  - Ready never depends on ready; it depends only on valid and rr_ptr.
- RAM drive (combinational from the winner):
  - ram_we_out = req_we of winner; ram_addr_out and ram_wdata_out = winner slices.
  - Idle cycle: ram_we_out = 0, ram_addr_out = 0, ram_wdata_out = 0. This causes a harmless read of address 0; no rsp is generated.
- Pointer: on acceptance, rr_ptr <= (winner + 1) mod NUM_REQ; otherwise hold.
- Read response:
  - Read accepted at edge N -> rsp_valid_out[winner] = 1 during cycle N+1.
  - rsp_rdata_out = ram_rdata_in in that cycle (pass-through, no extra register).
  - Latency is exactly 1 cycle; there is no response backpressure, so requesters must sink the data.
- Write response: none; a write completes at the acceptance edge.
- Back-to-back:
  - One access per cycle, 100% throughput while any request is valid.
  - A write to address A at edge N followed by a read of A at edge N+1 returns the new data.
- Simultaneous requests: serialized by round-robin; with all NUM_REQ continuously valid, each is granted once every NUM_REQ cycles.
- Requester protocol:
  - Hold valid and payload stable until accepted.
  - The arbiter does not check this; dropping valid before grant withdraws the request.
- Single valid requester: granted every cycle regardless of rr_ptr.

Optional Feature:
- Macro: SPRAM_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt_out, width NUM_REQ*16.
  - Per requester, a 16-bit counter increments each cycle valid=1 & ready=0, saturating at 16'hFFFF.
  - Counters reset to 0 on rst_n.
- Undefined: port and counters are absent; functional behaviour is otherwise identical.

Decomposition:
- Package spram_arb_pkg holds:
  - STAT_CNT_W = 16;
  - function clog2_min1(n), returning the index width (minimum 1);
  - typedef of the requester index type for the maximum NUM_REQ of 8.
- Sub-module spram_rr_arbiter: generic NUM_REQ round-robin grant logic plus the rr_ptr register, with inputs valid/accept and outputs one-hot grant plus grant index.
- The top module owns the RAM muxing, the response tag register and the stats counters.

Test Plan (NUM_REQ=2, 32-bit, 10-bit address, arbiter connected to the RAM model):
- Req0 writes 0xDEADBEEF to addr 0x005, then the next cycle reads 0x005 -> ready0 both cycles; rsp_valid_out=2'b01 one cycle after the read; rsp_rdata_out=0xDEADBEEF.
- Both requesters valid continuously, reads of 0x010 (req0) and 0x020 (req1) -> grants alternate 01,10,01,10 starting at req0 after reset; rsp_valid follows grant one cycle later with matching data.
- Only req1 valid for 4 cycles -> ready1 every cycle; rsp_valid_out=2'b10 on cycles 2..5.
- Read from req0 accepted, rst_n pulsed low in the same cycle -> rsp_valid_out stays 0; after release rr_ptr=0 and req0 wins a tie.
- Req1 write 0x1 to 0x3FF concurrent with req0 read 0x3FF, rr_ptr=1 -> write granted first, read next cycle returns 0x00000001.
- With SPRAM_ARB_STATS_EN defined: req0 and req1 continuously valid for 10 cycles -> each stall counter = 5. Force 70000 stall cycles on one requester -> that counter reads 0xFFFF.
